row_sum_accum: RTL and testbench

- Downstream reduction stage for the elementwise multiplier array in the matrix-multiply datapath.
- Takes the n x n grid of rounded 27-bit products and reduces each row i over j with a registered adder tree, giving sum[i].
- Accumulates those sums over a burst of beats (first/last framed), so inner dimensions larger than n are handled in chunks of n.
- Format: 27-bit two's complement, 16 fractional bits (1.0 = 27'h0010000).

---
 rtl/row_sum_accum.sv | 147 ++++++++++++++
 tb/tb_row_sum_accum.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/row_sum_accum.sv
// row_sum_accum: per-row reduction of an n x n product grid through a
// registered adder tree, followed by a first/last framed burst accumulator.
// Values are 27-bit two's complement with 16 fractional bits; the tree and
// accumulator carry GUARD extra integer bits (W = 27 + GUARD).
// Optional macro ROW_SUM_SAT_EN: saturate the 27-bit result instead of wrapping.
// Requires n >= 2 (at least one tree level).
module row_sum_accum #(
  parameter int n     = 6,
  parameter int GUARD = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [n-1:0][n-1:0][26:0]  dataa,
  output logic [n-1:0][26:0]         result,
  output logic                       out_valid
);

  localparam int W = 27 + GUARD;
  localparam int L = $clog2(n);

  // Number of live terms per row after k pairwise-add levels.
  function automatic int level_cnt(input int k);
    return (n + (1 << k) - 1) >> k;
  endfunction

  // Reduce an accumulator value to the 27-bit output format.
  function automatic logic [26:0] narrow(input logic signed [W-1:0] v);
`ifdef ROW_SUM_SAT_EN
    logic signed [W-1:0] hi;
    logic signed [W-1:0] lo;
    hi = {{GUARD{1'b0}}, 27'h3FFFFFF};
    lo = {{GUARD{1'b1}}, 27'h4000000};
    if (v > hi) return 27'h3FFFFFF;
    else if (v < lo) return 27'h4000000;
    else return v[26:0];
`else
    return v[26:0];
`endif
  endfunction

  // Column n is a permanent zero so an odd leftover term adds with zero,
  // which is exactly a pass-through register at that level.
  logic signed [W-1:0] term   [n][n+1];
  logic signed [W-1:0] tree_q [1:L][n][n+1];

  genvar gi, gr, gc;

  for (gr = 0; gr < n; gr++) begin : g_row
    for (gc = 0; gc < n; gc++) begin : g_col
      assign term[gr][gc] = {{GUARD{dataa[gr][gc][26]}}, dataa[gr][gc]};
    end
    assign term[gr][n] = '0;
  end

  for (gi = 1; gi <= L; gi++) begin : g_level
    localparam int NXT = level_cnt(gi);
    logic signed [W-1:0] src [n][n+1];

    if (gi == 1) begin : g_from_inputs
      assign src = term;
    end else begin : g_from_tree
      assign src = tree_q[gi-1];
    end

    // One registered pairwise-add level; columns past the live count stay zero.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int r = 0; r < n; r++)
          for (int c = 0; c <= n; c++)
            tree_q[gi][r][c] <= '0;
      end else if (en) begin
        for (int r = 0; r < n; r++) begin
          for (int c = 0; c < NXT; c++)
            tree_q[gi][r][c] <= src[r][2*c] + src[r][2*c+1];
          for (int c = NXT; c <= n; c++)
            tree_q[gi][r][c] <= '0;
        end
      end
    end
  end

  logic [L-1:0] vld_q, fst_q, lst_q;
  logic         tree_vld, tree_fst, tree_lst;

  // Beat framing travels alongside the tree so it lines up with the row sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      fst_q[0] <= in_first;
      lst_q[0] <= in_last;
      for (int k = 1; k < L; k++) begin
        vld_q[k] <= vld_q[k-1];
        fst_q[k] <= fst_q[k-1];
        lst_q[k] <= lst_q[k-1];
      end
    end
  end

  assign tree_vld = vld_q[L-1];
  assign tree_fst = fst_q[L-1];
  assign tree_lst = lst_q[L-1];

  logic signed [W-1:0] acc_q [n];
  logic signed [W-1:0] acc_d [n];
  logic [n-1:0][26:0]  result_q;
  logic                out_valid_q;

  // Next accumulator value: restart on first, add otherwise, hold on invalid beats.
  always_comb begin
    for (int r = 0; r < n; r++) begin
      acc_d[r] = acc_q[r];
      if (tree_vld) begin
        if (tree_fst) acc_d[r] = tree_q[L][r][0];
        else          acc_d[r] = acc_q[r] + tree_q[L][r][0];
      end
    end
  end

  // Accumulator and output registers; a valid last beat publishes the new sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < n; r++) acc_q[r] <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else if (en) begin
      for (int r = 0; r < n; r++) acc_q[r] <= acc_d[r];
      if (tree_vld && tree_lst) begin
        for (int r = 0; r < n; r++) result_q[r] <= narrow(acc_d[r]);
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_row_sum_accum.sv
// Directed testbench for row_sum_accum (n = 6, latency 4 en-cycles).
module tb_row_sum_accum;

  localparam int N = 6;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       en;
  logic                       in_valid;
  logic                       in_first;
  logic                       in_last;
  logic [N-1:0][N-1:0][26:0]  dataa;
  logic [N-1:0][26:0]         result;
  logic                       out_valid;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  row_sum_accum #(.n(N), .GUARD(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .dataa     (dataa),
    .result    (result),
    .out_valid (out_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [26:0] v, input logic f, input logic l);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        dataa[r][c] = v;
    in_valid = 1'b1;
    in_first = f;
    in_last  = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    idle();
    dataa = '0;
    step();
    step();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid);
    else passed++;
    for (int r = 0; r < N; r++) begin
      checks++;
      if (result[r] !== 27'h0) $display("FAIL reset_result[%0d] got %h want 0000000", r, result[r]);
      else passed++;
    end
  endtask

  task automatic test_single_beat();
    drive_beat(27'h0010000, 1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) idle();
      checks++;
      if (out_valid !== 1'(c == 4)) $display("FAIL single_ov c=%0d got %b want %b", c, out_valid, c == 4);
      else passed++;
      if (c == 4) begin
        for (int r = 0; r < N; r++) begin
          checks++;
          if (result[r] !== 27'h0060000) $display("FAIL single_result[%0d] got %h want 0060000", r, result[r]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_three_beat();
    drive_beat(27'h0010000, 1'b1, 1'b0);
    step();
    drive_beat(27'h7FF8000, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL three_ov_beat1 got %b want 0", out_valid);
    else passed++;
    step();
    drive_beat(27'h0004000, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL three_ov_beat2 got %b want 0", out_valid);
    else passed++;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) idle();
      checks++;
      if (out_valid !== 1'(c == 4)) $display("FAIL three_ov c=%0d got %b want %b", c, out_valid, c == 4);
      else passed++;
      if (c == 4) begin
        for (int r = 0; r < N; r++) begin
          checks++;
          if (result[r] !== 27'h0048000) $display("FAIL three_result[%0d] got %h want 0048000", r, result[r]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_stall();
    drive_beat(27'h0010000, 1'b1, 1'b1);
    step();
    idle();
    en = 1'b0;
    for (int s = 1; s <= 5; s++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || result[0] !== 27'h0048000)
        $display("FAIL stall_frozen s=%0d got ov=%b res=%h want ov=0 res=0048000", s, out_valid, result[0]);
      else passed++;
    end
    en = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      step();
      checks++;
      if (out_valid !== 1'(c == 4)) $display("FAIL stall_ov c=%0d got %b want %b", c, out_valid, c == 4);
      else passed++;
      if (c == 4) begin
        for (int r = 0; r < N; r++) begin
          checks++;
          if (result[r] !== 27'h0060000) $display("FAIL stall_result[%0d] got %h want 0060000", r, result[r]);
          else passed++;
        end
        en = 1'b0;
        for (int s = 1; s <= 2; s++) begin
          step();
          checks++;
          if (out_valid !== 1'b1) $display("FAIL stall_hold_ov s=%0d got %b want 1", s, out_valid);
          else passed++;
        end
        en = 1'b1;
      end
    end
  endtask

  task automatic test_overflow();
    logic [26:0] vin [2];
    logic [26:0] vexp [2];
    vin[0] = 27'h3FFFFFF;
    vin[1] = 27'h4000000;
`ifdef ROW_SUM_SAT_EN
    vexp[0] = 27'h3FFFFFF;
    vexp[1] = 27'h4000000;
`else
    vexp[0] = 27'h7FFFFFA;
    vexp[1] = 27'h0000000;
`endif
    for (int t = 0; t < 2; t++) begin
      drive_beat(vin[t], 1'b1, 1'b1);
      for (int c = 1; c <= 5; c++) begin
        step();
        if (c == 1) idle();
        checks++;
        if (out_valid !== 1'(c == 4)) $display("FAIL ovf%0d_ov c=%0d got %b want %b", t, c, out_valid, c == 4);
        else passed++;
        if (c == 4) begin
          for (int r = 0; r < N; r++) begin
            checks++;
            if (result[r] !== vexp[t]) $display("FAIL ovf%0d_result[%0d] got %h want %h", t, r, result[r], vexp[t]);
            else passed++;
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive_beat(27'h0010000, 1'b1, 1'b0);
    step();
    drive_beat(27'h0010000, 1'b0, 1'b0);
    step();
    idle();
    reset = 1'b1;
    en    = 1'b0;
    step();
    reset = 1'b0;
    en    = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || result[0] !== 27'h0) $display("FAIL rstmid_clear got ov=%b res=%h want ov=0 res=0000000", out_valid, result[0]);
    else passed++;
    for (int s = 1; s <= 4; s++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL rstmid_spurious s=%0d got %b want 0", s, out_valid);
      else passed++;
    end
    drive_beat(27'h0008000, 1'b1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) idle();
      checks++;
      if (out_valid !== 1'(c == 4)) $display("FAIL rstmid_ov c=%0d got %b want %b", c, out_valid, c == 4);
      else passed++;
      if (c == 4) begin
        for (int r = 0; r < N; r++) begin
          checks++;
          if (result[r] !== 27'h0030000) $display("FAIL rstmid_result[%0d] got %h want 0030000", r, result[r]);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    drive_beat(27'h0010000, 1'b1, 1'b1);
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) drive_beat(27'h0020000, 1'b1, 1'b1);
      if (c == 2) idle();
      checks++;
      if (out_valid !== 1'(c == 4 || c == 5)) $display("FAIL b2b_ov c=%0d got %b want %b", c, out_valid, c == 4 || c == 5);
      else passed++;
      if (c == 4 || c == 5) begin
        for (int r = 0; r < N; r++) begin
          checks++;
          if (result[r] !== ((c == 4) ? 27'h0060000 : 27'h00C0000))
            $display("FAIL b2b_result c=%0d [%0d] got %h want %h", c, r, result[r], (c == 4) ? 27'h0060000 : 27'h00C0000);
          else passed++;
        end
      end
    end
  endtask

  task automatic test_last_no_valid();
    drive_beat(27'h0010000, 1'b1, 1'b1);
    in_valid = 1'b0;
    for (int s = 1; s <= 6; s++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) $display("FAIL novalid_ov s=%0d got %b want 0", s, out_valid);
      else passed++;
    end
    idle();
    checks++;
    if (result[0] !== 27'h00C0000) $display("FAIL novalid_result got %h want 00C0000", result[0]);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_three_beat();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_back_to_back();
    test_last_no_valid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
